// File: rtl/lsioc_pkg.sv
// Shared LSIOC request/response encodings, TL-UL opcode enums and bridge FSM state type.
package lsioc_pkg;

  localparam logic [2:0] LsiocOpcRead  = 3'b000;
  localparam logic [2:0] LsiocOpcWrite = 3'b001;
  localparam logic [2:0] LsiocOpcXor   = 3'b111;
  localparam logic [2:0] LsiocOpcOr    = 3'b101;
  localparam logic [2:0] LsiocOpcAnd   = 3'b100;
  localparam logic [2:0] LsiocOpcSwap  = 3'b110;

  localparam logic [1:0] LsiocRspOk     = 2'b00;
  localparam logic [1:0] LsiocRspAmoErr = 2'b01;
  localparam logic [1:0] LsiocRspErr    = 2'b10;

  typedef enum logic [2:0] {
    TlPutFull    = 3'd0,
    TlPutPartial = 3'd1,
    TlArith      = 3'd2,
    TlLogical    = 3'd3,
    TlGet        = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TlLogXor  = 3'd0,
    TlLogOr   = 3'd1,
    TlLogAnd  = 3'd2,
    TlLogSwap = 3'd3
  } tl_log_param_e;

  typedef enum logic [2:0] {
    TlAccessAck     = 3'd0,
    TlAccessAckData = 3'd1
  } tl_d_op_e;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t StIdle  = 2'd0;
  localparam fsm_state_t StIssue = 2'd1;
  localparam fsm_state_t StWait  = 2'd2;
  localparam fsm_state_t StResp  = 2'd3;

endpackage

// File: rtl/tl_lsioc_bridge.sv
// TL-UL slave to LSIOC master bridge: one outstanding request, local deny decode and a
// response watchdog that fences off late replies from timed-out requests.
module tl_lsioc_bridge
  import lsioc_pkg::*;
#(
  parameter int unsigned    AW        = 32,
  parameter int unsigned    SW        = 4,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter logic [AW-1:0]  WIN_MASK  = 'hF,
  parameter int unsigned    TIMEOUT   = 255
) (
  input  logic          lsioc_clk_i,
  input  logic          lsioc_rstn_i,
  input  logic          tl_a_valid_i,
  output logic          tl_a_ready_o,
  input  logic [2:0]    tl_a_opcode_i,
  input  logic [2:0]    tl_a_param_i,
  input  logic [1:0]    tl_a_size_i,
  input  logic [SW-1:0] tl_a_source_i,
  input  logic [AW-1:0] tl_a_address_i,
  input  logic [3:0]    tl_a_mask_i,
  input  logic [31:0]   tl_a_data_i,
  output logic          tl_d_valid_o,
  input  logic          tl_d_ready_i,
  output logic [2:0]    tl_d_opcode_o,
  output logic [1:0]    tl_d_size_o,
  output logic [SW-1:0] tl_d_source_o,
  output logic          tl_d_denied_o,
  output logic          tl_d_corrupt_o,
  output logic [31:0]   tl_d_data_o,
  output logic          lsioc_req_vld_o,
  output logic [1:0]    lsioc_req_sbsp_o,
  output logic [31:0]   lsioc_req_data_o,
  output logic [2:0]    lsioc_req_opc_o,
  output logic [1:0]    lsioc_req_bmsk_o,
  input  logic          lsioc_req_busy_i,
  input  logic          lsioc_rsp_vld_i,
  input  logic [31:0]   lsioc_rsp_data_i,
  input  logic [1:0]    lsioc_rsp_err_i,
  output logic          lsioc_rsp_busy_o
);

  fsm_state_t    state_q, state_d;
  logic          stale_q, stale_d;
  logic [31:0]   timer_q, timer_d;
  logic          req_vld_q, req_vld_d;
  logic [1:0]    req_sbsp_q, req_sbsp_d;
  logic [31:0]   req_data_q, req_data_d;
  logic [2:0]    req_opc_q, req_opc_d;
  logic [1:0]    req_bmsk_q, req_bmsk_d;
  logic          d_valid_q, d_valid_d;
  logic [2:0]    d_opcode_q, d_opcode_d;
  logic [1:0]    d_size_q, d_size_d;
  logic [SW-1:0] d_source_q, d_source_d;
  logic          d_denied_q, d_denied_d;
  logic          d_corrupt_q, d_corrupt_d;
  logic [31:0]   d_data_q, d_data_d;

  logic       dec_deny;
  logic [2:0] dec_opc;
  logic [2:0] dec_d_op;
  logic       a_fire;
  logic       rsp_accept;
  logic       rsp_err;
  logic       timeout_hit;
  logic       unused_mask;

  assign unused_mask      = ^tl_a_mask_i;
  assign tl_a_ready_o     = (state_q == StIdle);
  assign a_fire           = tl_a_valid_i & tl_a_ready_o;
  assign lsioc_rsp_busy_o = 1'b0;
  // The first reply after a timeout belongs to the abandoned request.
  assign rsp_accept       = lsioc_rsp_vld_i & ~stale_q;
  assign rsp_err          = (lsioc_rsp_err_i != LsiocRspOk);
  assign timeout_hit      = (TIMEOUT != 0) && (timer_q == TIMEOUT);

  always_comb begin
    dec_deny = 1'b0;
    dec_opc  = LsiocOpcRead;
    case (tl_a_opcode_i)
      TlGet:                   dec_opc = LsiocOpcRead;
      TlPutFull, TlPutPartial: dec_opc = LsiocOpcWrite;
      TlLogical: begin
        case (tl_a_param_i)
          TlLogXor:  dec_opc = LsiocOpcXor;
          TlLogOr:   dec_opc = LsiocOpcOr;
          TlLogAnd:  dec_opc = LsiocOpcAnd;
          TlLogSwap: dec_opc = LsiocOpcSwap;
          default:   dec_deny = 1'b1;
        endcase
      end
      default: dec_deny = 1'b1;
    endcase
    if (tl_a_size_i == 2'd3) dec_deny = 1'b1;
    if ((tl_a_address_i & ~WIN_MASK) != BASE_ADDR) dec_deny = 1'b1;
    dec_d_op = ((tl_a_opcode_i == TlPutFull) || (tl_a_opcode_i == TlPutPartial)) ?
               TlAccessAck : TlAccessAckData;
  end

  always_comb begin
    state_d     = state_q;
    stale_d     = stale_q;
    timer_d     = timer_q;
    req_vld_d   = req_vld_q;
    req_sbsp_d  = req_sbsp_q;
    req_data_d  = req_data_q;
    req_opc_d   = req_opc_q;
    req_bmsk_d  = req_bmsk_q;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_data_d    = d_data_q;

    if (lsioc_rsp_vld_i && stale_q) stale_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (a_fire) begin
          d_opcode_d = dec_d_op;
          d_size_d   = tl_a_size_i;
          d_source_d = tl_a_source_i;
          req_sbsp_d = tl_a_address_i[3:2];
          req_data_d = tl_a_data_i;
          req_opc_d  = dec_opc;
          req_bmsk_d = tl_a_size_i;
          if (dec_deny) begin
            state_d     = StResp;
            d_valid_d   = 1'b1;
            d_denied_d  = 1'b1;
            d_corrupt_d = (dec_d_op == TlAccessAckData);
            d_data_d    = '0;
          end else begin
            state_d   = StIssue;
            req_vld_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (!lsioc_req_busy_i) begin
          state_d   = StWait;
          req_vld_d = 1'b0;
          timer_d   = '0;
        end
      end
      StWait: begin
        if (rsp_accept) begin
          state_d     = StResp;
          d_valid_d   = 1'b1;
          d_denied_d  = rsp_err;
          d_corrupt_d = rsp_err && (d_opcode_q == TlAccessAckData);
          d_data_d    = rsp_err ? 32'd0 : lsioc_rsp_data_i;
        end else if (timeout_hit) begin
          state_d     = StResp;
          stale_d     = 1'b1;
          d_valid_d   = 1'b1;
          d_denied_d  = 1'b1;
          d_corrupt_d = (d_opcode_q == TlAccessAckData);
          d_data_d    = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StResp: begin
        if (tl_d_ready_i) begin
          state_d   = StIdle;
          d_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge lsioc_clk_i or negedge lsioc_rstn_i) begin
    if (!lsioc_rstn_i) begin
      state_q     <= StIdle;
      stale_q     <= 1'b0;
      timer_q     <= '0;
      req_vld_q   <= 1'b0;
      req_sbsp_q  <= '0;
      req_data_q  <= '0;
      req_opc_q   <= '0;
      req_bmsk_q  <= '0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      stale_q     <= stale_d;
      timer_q     <= timer_d;
      req_vld_q   <= req_vld_d;
      req_sbsp_q  <= req_sbsp_d;
      req_data_q  <= req_data_d;
      req_opc_q   <= req_opc_d;
      req_bmsk_q  <= req_bmsk_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_data_q    <= d_data_d;
    end
  end

  assign tl_d_valid_o     = d_valid_q;
  assign tl_d_opcode_o    = d_opcode_q;
  assign tl_d_size_o      = d_size_q;
  assign tl_d_source_o    = d_source_q;
  assign tl_d_denied_o    = d_denied_q;
  assign tl_d_corrupt_o   = d_corrupt_q;
  assign tl_d_data_o      = d_data_q;
  assign lsioc_req_vld_o  = req_vld_q;
  assign lsioc_req_sbsp_o = req_sbsp_q;
  assign lsioc_req_data_o = req_data_q;
  assign lsioc_req_opc_o  = req_opc_q;
  assign lsioc_req_bmsk_o = req_bmsk_q;

endmodule
